// File: rtl/color_pkg.sv
// Shared encodings for the colour-sensor front end and the motor block.
package color_pkg;

  // Steering commands consumed by the motor block
  localparam logic [1:0] CMD_LEFT  = 2'b00;  // yellow
  localparam logic [1:0] CMD_RIGHT = 2'b01;  // red
  localparam logic [1:0] CMD_STOP  = 2'b10;  // black
  localparam logic [1:0] CMD_FWD   = 2'b11;  // green

  // TCS3200 photodiode filter select, as {s2, s3}
  localparam logic [1:0] FILT_RED   = 2'b00;
  localparam logic [1:0] FILT_GREEN = 2'b11;
  localparam logic [1:0] FILT_BLUE  = 2'b01;

  // Measurement sequencer states; ST_SET stands for SET_R/SET_G/SET_B,
  // the colour being measured is held separately in a chan_t register.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET,
    ST_SETTLE,
    ST_GATE,
    ST_CLASSIFY
  } fsm_t;

  typedef enum logic [1:0] {
    CH_R,
    CH_G,
    CH_B
  } chan_t;

  // Filter code the sensor needs while a given channel is measured
  function automatic logic [1:0] filter_of(input chan_t ch);
    case (ch)
      CH_G:    filter_of = FILT_GREEN;
      CH_B:    filter_of = FILT_BLUE;
      default: filter_of = FILT_RED;
    endcase
  endfunction

endpackage

// File: rtl/freq_edge_counter.sv
// Synchronises the sensor pulse train, detects rising edges and counts
// them (saturating) while enabled. 'total' is the value the counter takes
// on the next clock, so a window-end latch still catches an edge arriving
// on the final enabled clock.
module freq_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             freq_in,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] total
);

  logic [2:0] sync;
  logic       rise;

  // Two-flop synchroniser plus one history flop for edge detection
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync <= '0;
    else       sync <= {sync[1:0], freq_in};
  end

  assign rise = sync[1] & ~sync[2];

  // Saturating increment: the count sticks at all-ones instead of wrapping
  always_comb begin
    total = count;
    if (en && rise && (count != '1)) total = count + CNT_W'(1);
  end

  // Edge counter register with synchronous clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset)    count <= '0;
    else if (clr) count <= '0;
    else          count <= total;
  end

endmodule

// File: rtl/color_cmd_encoder.sv
// Sequences the TCS3200 through red/green/blue, counts sensor edges per
// gate window, classifies the frame and commits a steering command after
// CONFIRM consecutive identical classifications.
module color_cmd_encoder
  import color_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 5000,
  parameter int GATE_CYCLES   = 50000,
  parameter int BLACK_MAX     = 40,
  parameter int MARGIN        = 20,
  parameter int CONFIRM       = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic       freq_in,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       s3,
  output logic       led,
  output logic [1:0] state,
  output logic       state_valid
);

  localparam int TMR_MAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int CONF_W  = $clog2(CONFIRM + 1);
  localparam logic [CNT_W:0] BLACK_X  = (CNT_W+1)'(BLACK_MAX);
  localparam logic [CNT_W:0] MARGIN_X = (CNT_W+1)'(MARGIN);

  fsm_t              fsm, fsm_nxt;
  chan_t             chan, chan_nxt;
  logic [TMR_W-1:0]  timer, timer_nxt;
  logic              cnt_clr, cnt_en, gate_end, do_classify;
  logic [CNT_W-1:0]  count, total;
  logic [CNT_W-1:0]  r_cnt, g_cnt, b_cnt;
  logic [1:0]        filt;
  logic [1:0]        cand, prev_cand;
  logic              cand_ok;
  logic [CONF_W-1:0] conf, conf_nxt;
  logic [CNT_W:0]    rx, gx, bx, rg_diff;

  // 20% output scaling is fixed
  assign s0 = 1'b1;
  assign s1 = 1'b0;
  assign {s2, s3} = filt;

  freq_edge_counter #(.CNT_W(CNT_W)) u_counter (
    .clock   (clock),
    .reset   (reset),
    .freq_in (freq_in),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .count   (count),
    .total   (total)
  );

  // Sequencer state, current channel and phase timer
  // NOTE: every control and datapath flop resets asynchronously so a mid-frame reset is immediate.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm   <= ST_IDLE;
      chan  <= CH_R;
      timer <= '0;
    end else begin
      fsm   <= fsm_nxt;
      chan  <= chan_nxt;
      timer <= timer_nxt;
    end
  end

  // Next-state and phase strobes; dropping run overrides everything
  // NOTE: all outputs get a default first so no path leaves one unassigned (no latches).
  always_comb begin
    fsm_nxt     = fsm;
    chan_nxt    = chan;
    timer_nxt   = '0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    gate_end    = 1'b0;
    do_classify = 1'b0;
    if (!run) begin
      fsm_nxt = ST_IDLE;
      cnt_clr = 1'b1;
    end else begin
      case (fsm)
        ST_IDLE: begin
          fsm_nxt  = ST_SET;
          chan_nxt = CH_R;
          cnt_clr  = 1'b1;
        end
        ST_SET: begin
          fsm_nxt = ST_SETTLE;
          cnt_clr = 1'b1;
        end
        ST_SETTLE: begin
          if (timer == TMR_W'(SETTLE_CYCLES - 1)) fsm_nxt = ST_GATE;
          else                                    timer_nxt = timer + TMR_W'(1);
        end
        ST_GATE: begin
          cnt_en = 1'b1;
          if (timer == TMR_W'(GATE_CYCLES - 1)) begin
            gate_end = 1'b1;
            case (chan)
              CH_R:    begin fsm_nxt = ST_SET; chan_nxt = CH_G; end
              CH_G:    begin fsm_nxt = ST_SET; chan_nxt = CH_B; end
              default: fsm_nxt = ST_CLASSIFY;
            endcase
          end else begin
            timer_nxt = timer + TMR_W'(1);
          end
        end
        ST_CLASSIFY: begin
          do_classify = 1'b1;
          fsm_nxt     = ST_SET;
          chan_nxt    = CH_R;
        end
        default: fsm_nxt = ST_IDLE;
      endcase
    end
  end

  // Frame classification in CNT_W+1 bits so sums with MARGIN never wrap
  always_comb begin
    rx      = {1'b0, r_cnt};
    gx      = {1'b0, g_cnt};
    bx      = {1'b0, b_cnt};
    rg_diff = (rx >= gx) ? (rx - gx) : (gx - rx);
    cand    = CMD_STOP;
    cand_ok = 1'b1;
    if (rx < BLACK_X && gx < BLACK_X && bx < BLACK_X)
      cand = CMD_STOP;
    else if (rx >= bx + MARGIN_X && gx >= bx + MARGIN_X && rg_diff < MARGIN_X)
      cand = CMD_LEFT;
    else if (rx >= gx + MARGIN_X && rx >= bx + MARGIN_X)
      cand = CMD_RIGHT;
    else if (gx >= rx + MARGIN_X && gx >= bx + MARGIN_X)
      cand = CMD_FWD;
    else
      cand_ok = 1'b0;
  end

  // Run length of identical candidates, saturating at CONFIRM
  always_comb begin
    conf_nxt = CONF_W'(1);
    if (conf != '0 && cand == prev_cand)
      conf_nxt = (conf == CONF_W'(CONFIRM)) ? conf : conf + CONF_W'(1);
  end

  // Count latches, filter drive, confirmation and command commit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      g_cnt       <= '0;
      b_cnt       <= '0;
      filt        <= FILT_RED;
      prev_cand   <= CMD_STOP;
      conf        <= '0;
      state       <= CMD_STOP;
      state_valid <= 1'b0;
      led         <= 1'b0;
    end else begin
      led         <= run;
      state_valid <= 1'b0;
      if (fsm_nxt == ST_SET) filt <= filter_of(chan_nxt);
      if (!run) begin
        r_cnt <= '0;
        g_cnt <= '0;
        b_cnt <= '0;
        conf  <= '0;
      end else begin
        if (gate_end) begin
          case (chan)
            CH_R:    r_cnt <= total;
            CH_G:    g_cnt <= total;
            default: b_cnt <= total;
          endcase
        end
        if (do_classify) begin
          if (cand_ok) begin
            prev_cand <= cand;
            conf      <= conf_nxt;
            if (conf_nxt == CONF_W'(CONFIRM)) begin
              state       <= cand;
              state_valid <= 1'b1;
            end
          end else begin
            conf <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_color_cmd_encoder.sv
// Directed bench for color_cmd_encoder. A sensor model picks an edge
// period from the filter the DUT selects; periods that divide the gate
// length give exact counts (100/period) independent of phase.
module tb_color_cmd_encoder;
  import color_pkg::*;

  localparam int S     = 4;
  localparam int G     = 100;
  localparam int C     = 2;
  localparam int FRAME = 3 * (1 + S + G) + 1;  // 316 clocks
  localparam int G_SAT = 200;                  // 100 edges into a 6-bit counter

  logic       clock = 1'b0;
  logic       reset, run, freq_in;
  logic       s0, s1, s2, s3, led, state_valid;
  logic [1:0] state;
  logic       run_sat, freq_sat;
  logic       sat_s0, sat_s1, sat_s2, sat_s3, sat_led, sat_valid;
  logic [1:0] sat_state;

  int prd_r = 0, prd_g = 0, prd_b = 0;
  int errors = 0, checks = 0;
  int pulses = 0, sat_pulses = 0;

  color_cmd_encoder #(
    .CNT_W(16), .SETTLE_CYCLES(S), .GATE_CYCLES(G),
    .BLACK_MAX(40), .MARGIN(20), .CONFIRM(C)
  ) u_dut (
    .clock(clock), .reset(reset), .run(run), .freq_in(freq_in),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3), .led(led),
    .state(state), .state_valid(state_valid)
  );

  color_cmd_encoder #(
    .CNT_W(6), .SETTLE_CYCLES(S), .GATE_CYCLES(G_SAT),
    .BLACK_MAX(40), .MARGIN(20), .CONFIRM(C)
  ) u_sat (
    .clock(clock), .reset(reset), .run(run_sat), .freq_in(freq_sat),
    .s0(sat_s0), .s1(sat_s1), .s2(sat_s2), .s3(sat_s3), .led(sat_led),
    .state(sat_state), .state_valid(sat_valid)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sensor model: rising edge every p clocks on the selected filter (0 = dark);
  // the saturation DUT sees a toggle every clock, i.e. an edge every 2 clocks.
  initial begin
    int cyc;
    int p;
    cyc      = 0;
    freq_in  = 1'b0;
    freq_sat = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      case ({s2, s3})
        FILT_RED:   p = prd_r;
        FILT_GREEN: p = prd_g;
        default:    p = prd_b;
      endcase
      freq_in  = (p != 0) && ((cyc % p) < (p / 2));
      freq_sat = ~freq_sat;
    end
  end

  // Pulse monitor, sampled on the active edge so each one-clock pulse counts once
  initial begin
    forever begin
      @(posedge clock);
      if (state_valid === 1'b1) pulses++;
      if (sat_valid === 1'b1) sat_pulses++;
    end
  end

  task automatic set_rgb(input int r, input int g, input int b);
    prd_r = r;
    prd_g = g;
    prd_b = b;
  endtask

  // Raise run and stop in the SET_R cycle of the first frame
  task automatic start_run();
    run = 1'b1;
    @(posedge clock);
    @(negedge clock);
  endtask

  // Advance one frame to the next SET_R cycle and check the frame's result
  task automatic frame_check(input string tag, input logic vexp, input logic [1:0] sexp);
    repeat (FRAME) @(posedge clock);
    @(negedge clock);
    check({tag, "_valid"}, state_valid, vexp);
    check({tag, "_state"}, state, sexp);
  endtask

  initial begin
    reset   = 1'b1;
    run     = 1'b0;
    run_sat = 1'b0;
    repeat (3) @(negedge clock);

    check("rst_state", state, CMD_STOP);
    check("rst_valid", state_valid, 1'b0);
    check("rst_led", led, 1'b0);
    check("rst_s0", s0, 1'b1);
    check("rst_s1", s1, 1'b0);
    check("rst_s2s3", {s2, s3}, 2'b00);

    reset   = 1'b0;
    run_sat = 1'b1;
    @(negedge clock);

    // 1: R=G=B=50 -> no candidate, nothing committed; filter sequence observed
    set_rgb(2, 2, 2);
    start_run();
    check("t1_led", led, 1'b1);
    check("t1_filt_red", {s2, s3}, FILT_RED);
    repeat (105) @(posedge clock);
    @(negedge clock);
    check("t1_filt_green", {s2, s3}, FILT_GREEN);
    repeat (105) @(posedge clock);
    @(negedge clock);
    check("t1_filt_blue", {s2, s3}, FILT_BLUE);
    repeat (106) @(posedge clock);
    @(negedge clock);
    check("t1_f1_valid", state_valid, 1'b0);
    check("t1_f1_state", state, CMD_STOP);
    frame_check("t1_f2", 1'b0, CMD_STOP);
    frame_check("t1_f3", 1'b0, CMD_STOP);

    // 2: R=50 G=10 B=10 -> red, committed on frame 2, repeated on frame 3
    set_rgb(2, 10, 10);
    frame_check("t2_f1", 1'b0, CMD_STOP);
    frame_check("t2_f2", 1'b1, CMD_RIGHT);
    frame_check("t2_f3", 1'b1, CMD_RIGHT);
    // R=50 G=25 B=0: |R-G| reaches the margin so not yellow, still red
    set_rgb(2, 4, 0);
    frame_check("t2_margin", 1'b1, CMD_RIGHT);

    // 3: R=50 G=50 B=10 -> yellow after two frames; one green frame does not commit
    set_rgb(2, 2, 10);
    frame_check("t3_f1", 1'b0, CMD_RIGHT);
    frame_check("t3_f2", 1'b1, CMD_LEFT);
    set_rgb(10, 2, 10);
    frame_check("t3_green1", 1'b0, CMD_LEFT);

    // 4: dark -> black committed on frame 2; counts of 20 are still black
    set_rgb(0, 0, 0);
    frame_check("t4_f1", 1'b0, CMD_LEFT);
    frame_check("t4_f2", 1'b1, CMD_STOP);
    set_rgb(5, 5, 5);
    frame_check("t4_black20", 1'b1, CMD_STOP);

    // 6: drop run in the green gate, restart 20 clocks later; confirm must restart
    set_rgb(0, 0, 0);
    repeat (150) @(posedge clock);
    @(negedge clock);
    check("t6_in_green", {s2, s3}, FILT_GREEN);
    run = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("t6_led_off", led, 1'b0);
    repeat (18) @(posedge clock);
    @(negedge clock);
    start_run();
    check("t6_led_on", led, 1'b1);
    check("t6_filt_restart", {s2, s3}, FILT_RED);
    frame_check("t6_f1", 1'b0, CMD_STOP);
    frame_check("t6_f2", 1'b1, CMD_STOP);
    set_rgb(2, 10, 10);
    frame_check("t6_red1", 1'b0, CMD_STOP);
    frame_check("t6_red2", 1'b1, CMD_RIGHT);

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("pulse_total", pulses, 8);

    // 5: saturating 6-bit counts (63) stay unclassified; a wrap would read as black
    check("t5_sat_led", sat_led, 1'b1);
    check("t5_sat_pulses", sat_pulses, 0);
    check("t5_sat_state", sat_state, CMD_STOP);

    // Async reset mid-frame: outputs return to reset values without a clock
    repeat (148) @(posedge clock);
    @(negedge clock);
    check("rst2_pre_filt", {s2, s3}, FILT_GREEN);
    reset = 1'b1;
    #1;
    check("rst2_state", state, CMD_STOP);
    check("rst2_valid", state_valid, 1'b0);
    check("rst2_led", led, 1'b0);
    check("rst2_s2s3", {s2, s3}, 2'b00);
    check("rst2_s0", s0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
